clause_eval_pipeline: RTL

Multi-lane, pipelined clause evaluator for the SAT solver's BCP datapath. Each cycle it accepts up to LANES clauses with their current variable assignments and classifies each clause as satisfied, unit, conflicting or unresolved. Unit implications go to an output FIFO one per cycle for the assignment/trail logic. A conflict halts the block until the controller issues a flush on backtrack.

---
 rtl/sat_pkg.sv | 29 ++
 rtl/clause_classifier.sv | 58 +++++
 rtl/clause_eval_pipeline.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sat_pkg.sv
// rtl/sat_pkg.sv - shared types for the clause evaluation pipeline
package sat_pkg;

  localparam int SAT_NUM_VARIABLE = 128;
  localparam int SAT_VAR_W        = $clog2(SAT_NUM_VARIABLE);
  localparam int SAT_CID_W        = 16;

  // Clause outcome given the current partial assignment
  typedef enum logic [1:0] {
    CLS_SAT      = 2'd0,
    CLS_CONFLICT = 2'd1,
    CLS_UNIT     = 2'd2,
    CLS_OPEN     = 2'd3
  } lane_class_t;

  // RUN evaluates batches; CONFLICT freezes everything until flush/reset
  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_CONFLICT = 1'b1
  } eval_state_t;

  // Per-lane S2 entry, also the FIFO entry format
  typedef struct packed {
    logic [SAT_VAR_W-1:0] variable;
    logic                 val;
    logic [SAT_CID_W-1:0] clause_id;
  } lane_res_t;

endpackage

// File: rtl/clause_classifier.sv
// rtl/clause_classifier.sv - combinational classification of one clause
module clause_classifier
  import sat_pkg::*;
#(
  parameter int VAR_PER_CLAUSE = 5,
  parameter int VAR_W          = SAT_VAR_W
) (
  input  logic [VAR_PER_CLAUSE-1:0]            mask_i,
  input  logic [VAR_PER_CLAUSE-1:0]            pole_i,
  input  logic [VAR_PER_CLAUSE-1:0]            unassign_i,
  input  logic [VAR_PER_CLAUSE-1:0]            val_i,
  input  logic [VAR_PER_CLAUSE-1:0][VAR_W-1:0] variable_i,
  output lane_class_t                          cls_o,
  output logic [VAR_W-1:0]                     free_var_o,
  output logic                                 free_val_o
);

  logic [VAR_PER_CLAUSE-1:0] lit_true;
  logic [VAR_PER_CLAUSE-1:0] lit_free;
  logic                      any_free;
  logic                      many_free;

  assign lit_true = mask_i & ~unassign_i & ~(val_i ^ pole_i);
  assign lit_free = mask_i & unassign_i;

  // Scan free literals: keep the lowest slot, note whether a second one exists
  always_comb begin
    any_free   = 1'b0;
    many_free  = 1'b0;
    free_var_o = '0;
    free_val_o = 1'b0;
    for (int s = 0; s < VAR_PER_CLAUSE; s++) begin
      if (lit_free[s]) begin
        if (any_free) begin
          many_free = 1'b1;
        end else begin
          free_var_o = variable_i[s];
          free_val_o = pole_i[s];
        end
        any_free = 1'b1;
      end
    end
  end

  // A true literal wins even if free literals remain
  always_comb begin
    if (|lit_true) begin
      cls_o = CLS_SAT;
    end else if (!any_free) begin
      cls_o = CLS_CONFLICT;
    end else if (!many_free) begin
      cls_o = CLS_UNIT;
    end else begin
      cls_o = CLS_OPEN;
    end
  end

endmodule

// File: rtl/clause_eval_pipeline.sv
// rtl/clause_eval_pipeline.sv - multi-lane BCP clause evaluator with implication FIFO
module clause_eval_pipeline
  import sat_pkg::*;
#(
  parameter int NUM_VARIABLE   = SAT_NUM_VARIABLE,
  parameter int VARIABLE_INDEX = $clog2(NUM_VARIABLE) - 1,
  parameter int VAR_PER_CLAUSE = 5,
  parameter int LANES          = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int CID_WIDTH      = SAT_CID_W
) (
  input  logic                                                    clock,
  input  logic                                                    reset,
  input  logic                                                    flush,
  input  logic                                                    in_valid,
  output logic                                                    in_ready,
  input  logic                                                    in_last,
  input  logic [LANES-1:0]                                        in_lane_valid,
  input  logic [LANES-1:0][CID_WIDTH-1:0]                         in_clause_id,
  input  logic [LANES-1:0][VAR_PER_CLAUSE-1:0]                    in_mask,
  input  logic [LANES-1:0][VAR_PER_CLAUSE-1:0]                    in_pole,
  input  logic [LANES-1:0][VAR_PER_CLAUSE-1:0]                    in_unassign,
  input  logic [LANES-1:0][VAR_PER_CLAUSE-1:0]                    in_val,
  input  logic [LANES-1:0][VAR_PER_CLAUSE-1:0][VARIABLE_INDEX:0]  in_variable,
  output logic                                                    imp_valid,
  input  logic                                                    imp_ready,
  output logic [VARIABLE_INDEX:0]                                 imp_variable,
  output logic                                                    imp_val,
  output logic [CID_WIDTH-1:0]                                    imp_clause_id,
  output logic                                                    conflict,
  output logic [CID_WIDTH-1:0]                                    conflict_clause_id,
  output logic                                                    done,
  output logic [CID_WIDTH-1:0]                                    unit_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]          PTR_ONE  = 1;
  localparam logic [LANES-1:0]     LANE_ONE = 1;
  localparam logic [CID_WIDTH-1:0] CID_ONE  = 1;

  // S1: raw accepted batch
  logic                                                   s1_valid_q, s1_valid_d;
  logic                                                   s1_last_q;
  logic [LANES-1:0]                                       s1_lane_valid_q;
  logic [LANES-1:0][CID_WIDTH-1:0]                        s1_clause_id_q;
  logic [LANES-1:0][VAR_PER_CLAUSE-1:0]                   s1_mask_q;
  logic [LANES-1:0][VAR_PER_CLAUSE-1:0]                   s1_pole_q;
  logic [LANES-1:0][VAR_PER_CLAUSE-1:0]                   s1_unassign_q;
  logic [LANES-1:0][VAR_PER_CLAUSE-1:0]                   s1_val_q;
  logic [LANES-1:0][VAR_PER_CLAUSE-1:0][VARIABLE_INDEX:0] s1_variable_q;

  // S2: pending units of the classified batch
  logic [LANES-1:0] s2_pend_q, s2_pend_d;
  lane_res_t        s2_res_q [LANES];
  lane_res_t        s2_res_d [LANES];
  logic             s2_last_q, s2_last_d;

  // FSM and status
  eval_state_t          state_q, state_d;
  logic                 conflict_q, conflict_d;
  logic [CID_WIDTH-1:0] conflict_id_q, conflict_id_d;
  logic                 done_q, done_d;
  logic [CID_WIDTH-1:0] unit_count_q, unit_count_d;

  // Implication FIFO
  lane_res_t   fifo_mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        fifo_full;
  logic        fifo_empty;
  lane_res_t   fifo_head;

  // Classifier outputs and lane decode
  lane_class_t           lane_cls      [LANES];
  logic [VARIABLE_INDEX:0] lane_free_var [LANES];
  logic                  lane_free_val [LANES];
  logic [LANES-1:0]      lane_active;
  logic [LANES-1:0]      unit_mask;
  logic [LANES-1:0]      conf_mask;
  logic [CID_WIDTH-1:0]  conf_id;

  // Handshake
  logic [LANES-1:0] push_onehot;
  logic             last_pend;
  lane_res_t        push_data;
  logic             pop_fire;
  logic             can_push;
  logic             push_fire;
  logic             s2_free;
  logic             s1_advance;
  logic             batch_conflict;
  logic             accept;
  logic             clear;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    clause_classifier #(
      .VAR_PER_CLAUSE (VAR_PER_CLAUSE),
      .VAR_W          (VARIABLE_INDEX + 1)
    ) u_classifier (
      .mask_i     (s1_mask_q[g]),
      .pole_i     (s1_pole_q[g]),
      .unassign_i (s1_unassign_q[g]),
      .val_i      (s1_val_q[g]),
      .variable_i (s1_variable_q[g]),
      .cls_o      (lane_cls[g]),
      .free_var_o (lane_free_var[g]),
      .free_val_o (lane_free_val[g])
    );
  end

  // Lane decode of the S1 batch; lowest conflicting lane supplies the ID
  always_comb begin
    lane_active = '0;
    unit_mask   = '0;
    conf_mask   = '0;
    conf_id     = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_active[l] = s1_lane_valid_q[l] & (|s1_mask_q[l]);
      unit_mask[l]   = lane_active[l] & (lane_cls[l] == CLS_UNIT);
      conf_mask[l]   = lane_active[l] & (lane_cls[l] == CLS_CONFLICT);
    end
    for (int l = LANES - 1; l >= 0; l--) begin
      if (conf_mask[l]) begin
        conf_id = s1_clause_id_q[l];
      end
    end
  end

  // Select the lowest pending unit of S2 as the push candidate
  always_comb begin
    push_onehot = s2_pend_q & (~s2_pend_q + LANE_ONE);
    last_pend   = (s2_pend_q & (s2_pend_q - LANE_ONE)) == '0;
    push_data   = '0;
    for (int l = 0; l < LANES; l++) begin
      if (push_onehot[l]) begin
        push_data = s2_res_q[l];
      end
    end
  end

  assign clear      = reset | flush;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_fire   = imp_ready & ~fifo_empty;
  // A same-cycle pop frees the slot, so a full FIFO can still take a push
  assign can_push   = ~fifo_full | pop_fire;
  assign push_fire  = (state_q == ST_RUN) & (|s2_pend_q) & can_push;
  assign s2_free    = ~(|s2_pend_q) | (push_fire & last_pend);
  assign s1_advance = (state_q == ST_RUN) & s1_valid_q & s2_free;
  assign batch_conflict = s1_advance & (|conf_mask);
  assign in_ready   = (state_q == ST_RUN) & ~flush & (~s1_valid_q | s1_advance);
  assign accept     = in_valid & in_ready;

  // FSM next state: a conflicting batch reaching S2 freezes the block
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && batch_conflict) begin
      state_d = ST_CONFLICT;
    end
  end

  // Next state of the pipeline stages and status registers
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s2_pend_d     = s2_pend_q;
    s2_res_d      = s2_res_q;
    s2_last_d     = s2_last_q;
    conflict_d    = conflict_q | batch_conflict;
    conflict_id_d = batch_conflict ? conf_id : conflict_id_q;
    unit_count_d  = unit_count_q;
    done_d        = (push_fire & last_pend & s2_last_q)
                  | (s1_advance & ~(|conf_mask) & ~(|unit_mask) & s1_last_q);

    if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
    // A batch accepted while the previous one conflicts is dropped with it
    if (accept && !batch_conflict) begin
      s1_valid_d = 1'b1;
    end

    if (push_fire) begin
      s2_pend_d = s2_pend_q & ~push_onehot;
      if (unit_count_q != '1) begin
        unit_count_d = unit_count_q + CID_ONE;
      end
    end

    if (s1_advance) begin
      s2_pend_d = batch_conflict ? '0 : unit_mask;
      s2_last_d = s1_last_q;
      for (int l = 0; l < LANES; l++) begin
        s2_res_d[l].variable  = lane_free_var[l];
        s2_res_d[l].val       = lane_free_val[l];
        s2_res_d[l].clause_id = s1_clause_id_q[l];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // S1 payload, captured on every accepted batch
  always_ff @(posedge clock) begin
    if (accept) begin
      s1_last_q       <= in_last;
      s1_lane_valid_q <= in_lane_valid;
      s1_clause_id_q  <= in_clause_id;
      s1_mask_q       <= in_mask;
      s1_pole_q       <= in_pole;
      s1_unassign_q   <= in_unassign;
      s1_val_q        <= in_val;
      s1_variable_q   <= in_variable;
    end
  end

  // Pipeline control, S2, FIFO and status registers
  always_ff @(posedge clock) begin
    if (clear) begin
      s1_valid_q    <= 1'b0;
      s2_pend_q     <= '0;
      s2_last_q     <= 1'b0;
      conflict_q    <= 1'b0;
      conflict_id_q <= '0;
      done_q        <= 1'b0;
      unit_count_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int l = 0; l < LANES; l++) begin
        s2_res_q[l] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      s1_valid_q    <= s1_valid_d;
      s2_pend_q     <= s2_pend_d;
      s2_last_q     <= s2_last_d;
      conflict_q    <= conflict_d;
      conflict_id_q <= conflict_id_d;
      done_q        <= done_d;
      unit_count_q  <= unit_count_d;
      for (int l = 0; l < LANES; l++) begin
        s2_res_q[l] <= s2_res_d[l];
      end
      if (push_fire) begin
        fifo_mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_fire) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  assign fifo_head          = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign imp_valid          = ~fifo_empty;
  assign imp_variable       = fifo_head.variable;
  assign imp_val            = fifo_head.val;
  assign imp_clause_id      = fifo_head.clause_id;
  assign conflict           = conflict_q;
  assign conflict_clause_id = conflict_id_q;
  assign done               = done_q;
  assign unit_count         = unit_count_q;

endmodule
